arbiter_prio8: RTL
==================

# arbiter_prio8

Eight-requester synchronous arbiter that shares one downstream resource between requesters, using the same MSB-first priority rule as the team's 8-bit priority encoder (`din[7]` highest). A grant is registered, held while the owner keeps its request high, and forcibly released after a configurable hold limit. It sits between the request sources and the shared resource: grant vector to the requesters, encoded owner index to the resource mux.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a single grant may be held; legal range 2..256.
- `clk` input, 1 bit: sole clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req` input, 8 bits: request lines; bit i high means requester i wants the resource.
- `gnt` output, 8 bits: one-hot grant, or all zero when idle.
- `gnt_id` output, 3 bits: binary index of the granted requester; 0 when idle.
- `gnt_valid` output, 1 bit: high exactly when `gnt` is non-zero.

## Operation
- Two states, IDLE and OWNED; reset state IDLE.
- IDLE:
  - If `req` ≠ 0, pick a winner by the priority rule, excluding the masked requester (see timeout) when any other bit is set.
  - Next state OWNED; load `gnt`/`gnt_id`; clear the hold counter.
  - If `req` = 0, remain IDLE with outputs zero.
- OWNED:
  - If `req[gnt_id]` is low, release: next state IDLE and outputs zero. This is a normal release and clears the mask.
  - Else if the hold counter equals `MAX_HOLD-1`, force release: next state IDLE, outputs zero, and mask `gnt_id` for the next arbitration only.
  - Else stay OWNED; hold counter +1.
- Requests from non-owners are ignored while OWNED. There is no preemption.
- Fixed priority order is 7, 6, …, 0 (highest index wins).
- A masked requester that is the only one requesting is granted anyway, so the arbiter never idles with requests pending.
- Hold counter width: `$clog2(MAX_HOLD)`. It saturates by construction and never wraps.
- `gnt_id` must always equal the encoded `gnt`. `gnt_valid` is `|gnt`.

## Timing
- Reset: `gnt` = 8'h00, `gnt_id` = 3'd0, `gnt_valid` = 0, state IDLE, hold counter 0, mask cleared, round-robin pointer = 0.
- Grant latency: `req` sampled in IDLE at edge N produces `gnt` valid after edge N+1 (one registered cycle).
- Release latency: owner request low at edge M produces `gnt` zero after edge M+1.
- Minimum one idle (all-zero) cycle between any two grants, including a re-grant to the same requester.
- Maximum continuous grant: `MAX_HOLD` cycles, followed by one idle cycle.
- Owner drops `req` on the same edge the counter reaches `MAX_HOLD-1`: treated as a normal release, no mask set.
- `rst` asserted mid-grant: outputs zero on the next edge, with all state at reset values. `rst` overrides everything.
- `req` changes while IDLE are sampled only at the edge; there is no combinational path from `req` to outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Rotating priority. A 3-bit pointer `last` is loaded with `gnt_id` on every grant.
  - Search order is `last-1`, `last-2`, …, `last` (mod 8), descending with wrap.
  - At reset `last` = 0, so the first order is 7…0, identical to fixed.
  - The timeout mask still applies.
- `ARB_ROUND_ROBIN_EN` not defined:
  - Fixed MSB-first priority.
  - No pointer register is present.

## Test plan
- Reset and idle: `rst` high 2 cycles, then `req` = 8'h00 for 5 cycles → `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0 throughout.
- Priority pick: `req` = 8'b11001100 in IDLE → one cycle later `gnt` = 8'h80 and `gnt_id` = 7. Drop `req[7]` → next cycle idle, following cycle `gnt` = 8'h40 and `gnt_id` = 6.
- Single-source sweep: `req` one-hot 8'h01 through 8'h80 with release between each → `gnt_id` equals the bit index, each granted one cycle after request.
- Timeout (`MAX_HOLD` = 4): `req` = 8'b10000001 held constant → `gnt` = 8'h80 for exactly 4 cycles, 1 idle cycle, then `gnt` = 8'h01 (bit 7 masked), then after its 4 cycles and 1 idle, `gnt` = 8'h80 again. With `req` = 8'h80 alone → re-granted after 1 idle cycle.
- Reset mid-grant: grant to requester 3 active, assert `rst` for 1 cycle → outputs zero the next cycle; with `req` = 8'h08 still high after reset, re-granted one cycle after `rst` falls.
- Round robin (`ARB_ROUND_ROBIN_EN`): `req` = 8'hFF with each owner releasing after 1 cycle → grant order 7, 6, 5, 4, 3, 2, 1, 0, 7; without the macro, order 7, 7, 7, ….

Source files
------------

// File: rtl/arbiter_prio8.sv
// arbiter_prio8: 8-way registered grant arbiter, MSB-first priority, hold limit with timeout mask; ARB_ROUND_ROBIN_EN selects rotating priority
module arbiter_prio8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);
  localparam int CW = $clog2(MAX_HOLD);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state, state_n;
  logic [7:0] gnt_n, unmasked, elig;
  logic [2:0] id_n, mask_id, mask_id_n, base, win, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic mask_v, mask_v_n, found;
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] last, last_n;
  assign base = last;
  // pointer follows every new grant so the search starts just below the last owner
  always_comb last_n = (state == IDLE && |req) ? win : last;
  // pointer register
  always_ff @(posedge clk) last <= rst ? 3'd0 : last_n;
`else
  assign base = 3'd0;
`endif
  // a timed-out owner is skipped once, unless it is the only requester
  assign unmasked = req & ~(8'd1 << mask_id);
  assign elig = (mask_v && |unmasked) ? unmasked : req;
  // descending search from base-1 with wrap; base 0 gives plain 7..0 order
  always_comb begin
    win = 3'd0;
    found = 1'b0;
    idx = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = base - 3'(k);
      if (!found && elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // next state, grant load/release, hold counter and timeout mask
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    id_n = gnt_id;
    cnt_n = cnt;
    mask_v_n = mask_v;
    mask_id_n = mask_id;
    if (state == IDLE) begin
      if (|req) begin
        state_n = OWNED;
        gnt_n = 8'd1 << win;
        id_n = win;
        cnt_n = '0;
        mask_v_n = 1'b0;
      end
    end else if (!req[gnt_id]) begin
      state_n = IDLE;
      gnt_n = 8'd0;
      id_n = 3'd0;
      mask_v_n = 1'b0;
    end else if (cnt == CW'(MAX_HOLD - 1)) begin
      state_n = IDLE;
      gnt_n = 8'd0;
      id_n = 3'd0;
      mask_v_n = 1'b1;
      mask_id_n = gnt_id;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 8'd0;
      gnt_id <= 3'd0;
      cnt <= '0;
      mask_v <= 1'b0;
      mask_id <= 3'd0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      cnt <= cnt_n;
      mask_v <= mask_v_n;
      mask_id <= mask_id_n;
    end
  end
  assign gnt_valid = |gnt;
endmodule
